axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Packet-level round-robin arbiter that merges NUM_SRC AXI-Stream slave ports onto one registered AXI-Stream master port. It sits in front of a shared stream consumer (DMA, FIFO, or the slave BFM in bench builds) and guarantees packets from different sources never interleave. It carries the full AXIS sideband set: tdata, tstrb, tkeep, tlast, tid, tdest and tuser.

## Interface
- NUM_SRC, 2: number of slave ports, legal range 2..8.
- DATA_W, 32: tdata width in bits, multiple of 8. tstrb and tkeep width is DATA_W/8.
- ID_W, 1: tid width.
- DEST_W, 1: tdest width.
- USER_W, 1: tuser width.
- aclk  in  1  Single clock; all logic rises on this edge.
- aresetn  in  1  Reset, asynchronous assert, active-low.
- s_tvalid  in  NUM_SRC  Per-source valid.
- s_tready  out  NUM_SRC  Per-source ready.
- s_tdata  in  NUM_SRC*DATA_W  Source i occupies slice [i*DATA_W +: DATA_W]. Same packing applies to every s_ vector below.
- s_tstrb, s_tkeep  in  NUM_SRC*DATA_W/8  Byte qualifiers.
- s_tlast  in  NUM_SRC  End of packet.
- s_tid, s_tdest, s_tuser  in  NUM_SRC*ID_W, NUM_SRC*DEST_W, NUM_SRC*USER_W  Sideband.
- m_tvalid, m_tready  out, in  1  Master handshake.
- m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  Single-source widths  Registered output beat.
- m_grant  out  $clog2(NUM_SRC)  Index of the source currently granted. Holds the last value while idle.
- m_busy  out  1  High in LOCKED state.

## Operation
- FSM has two states: IDLE and LOCKED.
- IDLE:
  - If any s_tvalid is high, select the first requester searching from (last_grant+1) mod NUM_SRC upward, wrapping.
  - Register the winner into sel, copy it to m_grant, and go to LOCKED.
  - If there are no requesters, stay in IDLE.
  - s_tready is all-zero in IDLE.
- LOCKED:
  - s_tready[sel] = !m_tvalid || m_tready. All other s_tready bits are 0.
  - On an accepted beat (s_tvalid[sel] && s_tready[sel]), load every field into the output register and set m_tvalid.
  - If m_tready is high and no new beat is accepted, clear m_tvalid.
  - On an accepted beat with s_tlast[sel]=1: set last_grant to sel and go to IDLE.
- Output register:
  - Holds its contents and m_tvalid while m_tvalid && !m_tready.
  - No field changes while stalled.
- Fields pass through unmodified. No width conversion and no tkeep-based byte removal.
- A source deasserting tvalid mid-packet does not release the grant. The arbiter waits indefinitely for that packet's tlast.
- Reset values, applied asynchronously when aresetn falls:
  - state=IDLE
  - m_tvalid=0, all m_ data and sideband fields=0
  - sel=0, m_grant=0
  - last_grant=NUM_SRC-1, so source 0 has priority first
  - m_busy=0, s_tready=0
- Reset mid-packet: the partial packet is abandoned and the downstream sees m_tvalid drop immediately. Recovery is the caller's responsibility.

## Timing
- Arbitration bubble: one cycle from the first s_tvalid in IDLE to the first s_tready assertion.
- Input-to-output latency: a beat accepted at edge k is on the m_ port with m_tvalid=1 after edge k.
- Throughput inside a packet: one beat per cycle while m_tready=1.
- Packet-to-packet gap on m_: at least one cycle, the IDLE arbitration cycle.
- s_tready depends combinationally on m_tready only. It never depends on s_tvalid.
- Simultaneous tlast acceptance and a new request: the new request is considered in the following IDLE cycle, using the updated last_grant.

## Configuration
- AXIS_ARB_PKT_LOCK_EN defined: behaviour as above. The grant is held until a beat with tlast is accepted.
- AXIS_ARB_PKT_LOCK_EN undefined:
  - Every accepted beat is treated as end-of-grant: last_grant updates and the FSM returns to IDLE after each beat.
  - Sources interleave beat by beat in round-robin order.
  - Maximum throughput drops to one beat per two cycles.
  - m_tlast is still forwarded unmodified.

## Test plan
- Single packet: source 1 sends 3 beats (tdata 0xA0000001..0xA0000003, last on beat 3) with m_tready=1. Required: m_ shows the same 3 beats on consecutive cycles, m_grant=1, m_busy falls after beat 3.
- Contention: sources 0 and 1 each present a 4-beat packet at the same time, from reset. Required: all of source 0's packet, a 1-cycle gap, then all of source 1's packet, with no interleaving.
- Fairness: NUM_SRC=4, all sources continuously offer 1-beat packets for 8 grants. Required: grant order 0,1,2,3,0,1,2,3.
- Backpressure: m_tready is held low for 5 cycles mid-packet at tdata 0x1234ABCD. Required: m_tdata, m_tvalid and all sideband fields stay stable, s_tready[sel] stays 0, and no beat is lost or duplicated.
- Reset mid-packet: aresetn is pulled low after beat 2 of 4. Required: m_tvalid=0 and m_busy=0 without waiting for a clock edge. After release, the first grant goes to the lowest-index requester.
- Lock disabled build (AXIS_ARB_PKT_LOCK_EN undefined): two sources each send a 2-beat packet. Required: m_ order is src0 beat1, src1 beat1, src0 beat2, src1 beat2.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter for AXI-Stream.
// Merges NUM_SRC slave streams onto one registered master stream. Every
// sideband field passes through untouched.
//
// Build option: define AXIS_ARB_PKT_LOCK_EN to hold the grant until the
// packet's tlast beat is accepted. Without it the grant is released after
// every accepted beat, so sources interleave beat by beat.
module axis_rr_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 1,
  parameter int unsigned DEST_W  = 1,
  parameter int unsigned USER_W  = 1
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  // Slave side, source i occupies slice [i*W +: W]
  input  logic [NUM_SRC-1:0]             s_tvalid,
  output logic [NUM_SRC-1:0]             s_tready,
  input  logic [NUM_SRC*DATA_W-1:0]      s_tdata,
  input  logic [NUM_SRC*DATA_W/8-1:0]    s_tstrb,
  input  logic [NUM_SRC*DATA_W/8-1:0]    s_tkeep,
  input  logic [NUM_SRC-1:0]             s_tlast,
  input  logic [NUM_SRC*ID_W-1:0]        s_tid,
  input  logic [NUM_SRC*DEST_W-1:0]      s_tdest,
  input  logic [NUM_SRC*USER_W-1:0]      s_tuser,
  // Master side
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [DATA_W-1:0]              m_tdata,
  output logic [DATA_W/8-1:0]            m_tstrb,
  output logic [DATA_W/8-1:0]            m_tkeep,
  output logic                           m_tlast,
  output logic [ID_W-1:0]                m_tid,
  output logic [DEST_W-1:0]              m_tdest,
  output logic [USER_W-1:0]              m_tuser,
  // Status
  output logic [$clog2(NUM_SRC)-1:0]     m_grant,
  output logic                           m_busy
);

  localparam int unsigned SelW  = $clog2(NUM_SRC);
  localparam int unsigned StrbW = DATA_W / 8;

`ifdef AXIS_ARB_PKT_LOCK_EN
  localparam bit PktLock = 1'b1;
`else
  localparam bit PktLock = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q;
  logic [SelW-1:0]   sel_q;
  logic [SelW-1:0]   grant_q;
  logic [SelW-1:0]   last_grant_q;

  logic              m_tvalid_q;
  logic [DATA_W-1:0] m_tdata_q;
  logic [StrbW-1:0]  m_tstrb_q;
  logic [StrbW-1:0]  m_tkeep_q;
  logic              m_tlast_q;
  logic [ID_W-1:0]   m_tid_q;
  logic [DEST_W-1:0] m_tdest_q;
  logic [USER_W-1:0] m_tuser_q;

  // Fields of the currently selected source
  logic              sel_tvalid;
  logic              sel_tlast;
  logic [DATA_W-1:0] sel_tdata;
  logic [StrbW-1:0]  sel_tstrb;
  logic [StrbW-1:0]  sel_tkeep;
  logic [ID_W-1:0]   sel_tid;
  logic [DEST_W-1:0] sel_tdest;
  logic [USER_W-1:0] sel_tuser;

  logic              out_free;
  logic              accept;
  logic              end_of_grant;
  logic              any_req;
  logic [SelW-1:0]   winner;
  logic [SelW-1:0]   cand;
  logic              found;

  assign sel_tvalid = s_tvalid[sel_q];
  assign sel_tlast  = s_tlast[sel_q];
  assign sel_tdata  = s_tdata[int'(sel_q) * DATA_W +: DATA_W];
  assign sel_tstrb  = s_tstrb[int'(sel_q) * StrbW +: StrbW];
  assign sel_tkeep  = s_tkeep[int'(sel_q) * StrbW +: StrbW];
  assign sel_tid    = s_tid[int'(sel_q) * ID_W +: ID_W];
  assign sel_tdest  = s_tdest[int'(sel_q) * DEST_W +: DEST_W];
  assign sel_tuser  = s_tuser[int'(sel_q) * USER_W +: USER_W];

  // Output register can take a beat when empty or draining this cycle.
  assign out_free     = !m_tvalid_q || m_tready;
  assign accept       = (state_q == StLocked) && sel_tvalid && out_free;
  // Without packet lock every accepted beat ends the grant.
  assign end_of_grant = accept && (sel_tlast || !PktLock);
  assign any_req      = |s_tvalid;

  // Round-robin search starting one past the last granted source.
  always_comb begin
    winner = last_grant_q;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = SelW'((32'(last_grant_q) + i) % NUM_SRC);
      if (!found && s_tvalid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Ready goes only to the locked source and never looks at s_tvalid.
  always_comb begin
    s_tready = '0;
    if (state_q == StLocked) begin
      s_tready[sel_q] = out_free;
    end
  end

  // Arbitration FSM: pick a winner in idle, hold it until the grant ends.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= SelW'(NUM_SRC - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            sel_q   <= winner;
            grant_q <= winner;
            state_q <= StLocked;
          end
        end
        StLocked: begin
          if (end_of_grant) begin
            last_grant_q <= sel_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Master output register: load on accept, drop valid once drained, hold when stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tstrb_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= '0;
      m_tdest_q  <= '0;
      m_tuser_q  <= '0;
    end else if (accept) begin
      m_tvalid_q <= 1'b1;
      m_tdata_q  <= sel_tdata;
      m_tstrb_q  <= sel_tstrb;
      m_tkeep_q  <= sel_tkeep;
      m_tlast_q  <= sel_tlast;
      m_tid_q    <= sel_tid;
      m_tdest_q  <= sel_tdest;
      m_tuser_q  <= sel_tuser;
    end else if (m_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tstrb  = m_tstrb_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tlast  = m_tlast_q;
  assign m_tid    = m_tid_q;
  assign m_tdest  = m_tdest_q;
  assign m_tuser  = m_tuser_q;
  assign m_grant  = grant_q;
  assign m_busy   = (state_q == StLocked);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (NUM_SRC=4).
// Expectations follow AXIS_ARB_PKT_LOCK_EN when it is defined for the build.
module tb_axis_rr_arbiter;

  localparam int NUM = 4;
  localparam int DW  = 32;

`ifdef AXIS_ARB_PKT_LOCK_EN
  localparam int BeatGap = 1;
`else
  localparam int BeatGap = 2;
`endif

  logic            aclk;
  logic            aresetn;
  logic [NUM-1:0]  s_tvalid;
  logic [NUM-1:0]  s_tready;
  logic [NUM*DW-1:0] s_tdata;
  logic [NUM*4-1:0] s_tstrb;
  logic [NUM*4-1:0] s_tkeep;
  logic [NUM-1:0]  s_tlast;
  logic [NUM*2-1:0] s_tid;
  logic [NUM*2-1:0] s_tdest;
  logic [NUM*2-1:0] s_tuser;
  logic            m_tvalid;
  logic            m_tready;
  logic [DW-1:0]   m_tdata;
  logic [3:0]      m_tstrb;
  logic [3:0]      m_tkeep;
  logic            m_tlast;
  logic [1:0]      m_tid;
  logic [1:0]      m_tdest;
  logic [1:0]      m_tuser;
  logic [1:0]      m_grant;
  logic            m_busy;

  axis_rr_arbiter #(
    .NUM_SRC (NUM),
    .DATA_W  (DW),
    .ID_W    (2),
    .DEST_W  (2),
    .USER_W  (2)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tstrb  (s_tstrb),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tid    (s_tid),
    .s_tdest  (s_tdest),
    .s_tuser  (s_tuser),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tstrb  (m_tstrb),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tdest  (m_tdest),
    .m_tuser  (m_tuser),
    .m_grant  (m_grant),
    .m_busy   (m_busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Per-source beat queues
  logic [31:0] bd [NUM][16];
  logic        bl [NUM][16];
  int          head [NUM];
  int          tail [NUM];

  logic [63:0] out_q [$];
  logic [63:0] exp_q [$];
  int          cyc_q [$];
  logic [1:0]  grant_q [$];
  logic [NUM-1:0] acc;
  logic [NUM-1:0] rdy_seen;
  logic [NUM-1:0] rdy_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Beat encoding: {pad, tid, tdest, tuser, tstrb, tkeep, tlast, tdata}
  function automatic logic [63:0] mk(input int src, input logic [31:0] d, input logic l);
    logic [1:0] s;
    s = 2'(src);
    return {17'b0, s, ~s, d[17:16], d[7:4], d[3:0] ^ 4'hF, l, d};
  endfunction

  function automatic logic [63:0] dut_beat();
    return {17'b0, m_tid, m_tdest, m_tuser, m_tstrb, m_tkeep, m_tlast, m_tdata};
  endfunction

  task automatic add(input int src, input logic [31:0] d, input logic l);
    bd[src][tail[src]] = d;
    bl[src][tail[src]] = l;
    tail[src]++;
  endtask

  task automatic expect_beat(input int src, input logic [31:0] d, input logic l);
    exp_q.push_back(mk(src, d, l));
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    out_q.delete();
    exp_q.delete();
    cyc_q.delete();
    grant_q.delete();
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic tick();
    logic [63:0] v;
    for (int i = 0; i < NUM; i++) begin
      if (head[i] != tail[i]) begin
        v = mk(i, bd[i][head[i]], bl[i][head[i]]);
        s_tvalid[i] = 1'b1;
      end else begin
        v = '0;
        s_tvalid[i] = 1'b0;
      end
      s_tdata[i*DW +: DW] = v[31:0];
      s_tlast[i]          = v[32];
      s_tkeep[i*4 +: 4]   = v[36:33];
      s_tstrb[i*4 +: 4]   = v[40:37];
      s_tuser[i*2 +: 2]   = v[42:41];
      s_tdest[i*2 +: 2]   = v[44:43];
      s_tid[i*2 +: 2]     = v[46:45];
    end
    #1;
    acc      = s_tvalid & s_tready;
    rdy_seen = s_tready;
    if (m_tvalid && m_tready) begin
      out_q.push_back(dut_beat());
      cyc_q.push_back(cyc);
      grant_q.push_back(m_grant);
    end
    @(posedge aclk);
    for (int i = 0; i < NUM; i++) begin
      if (acc[i]) head[i]++;
    end
    @(negedge aclk);
    cyc++;
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    m_tready = 1'b1;
    clear_all();
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic run_until(input int n, input int bound);
    int k;
    k = 0;
    while (out_q.size() < n && k < bound) begin
      tick();
      k++;
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic compare_out(input string tag);
    check({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < out_q.size()) check($sformatf("%s_beat%0d", tag, k), out_q[k], exp_q[k]);
    end
  endtask

  initial begin
    int n;
    aresetn  = 1'b0;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    s_tid    = '0;
    s_tdest  = '0;
    s_tuser  = '0;
    clear_all();
    @(negedge aclk);
    #1;

    // Reset state
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_busy", 64'(m_busy), 64'(0));
    check("rst_grant", 64'(m_grant), 64'(0));
    check("rst_tready", 64'(s_tready), 64'(0));
    check("rst_fields", dut_beat(), 64'(0));
    @(negedge aclk);

    // Single 3-beat packet from source 1
    do_reset();
    add(1, 32'hA0000001, 1'b0);
    add(1, 32'hA0000002, 1'b0);
    add(1, 32'hA0000003, 1'b1);
    expect_beat(1, 32'hA0000001, 1'b0);
    expect_beat(1, 32'hA0000002, 1'b0);
    expect_beat(1, 32'hA0000003, 1'b1);
    tick();
    check("single_busy_hi", 64'(m_busy), 64'(1));
    run_until(3, 20);
    compare_out("single");
    if (cyc_q.size() >= 3) begin
      check("single_gap1", 64'(cyc_q[1] - cyc_q[0]), 64'(BeatGap));
      check("single_gap2", 64'(cyc_q[2] - cyc_q[1]), 64'(BeatGap));
      check("single_grant", 64'(grant_q[0]), 64'(1));
    end
    check("single_busy_lo", 64'(m_busy), 64'(0));

    // Contention: sources 0 and 1, 4 beats each, from reset
    do_reset();
    for (int b = 1; b <= 4; b++) begin
      add(0, 32'hC0000000 + 32'(b), b == 4);
      add(1, 32'hC1000000 + 32'(b), b == 4);
    end
`ifdef AXIS_ARB_PKT_LOCK_EN
    for (int b = 1; b <= 4; b++) expect_beat(0, 32'hC0000000 + 32'(b), b == 4);
    for (int b = 1; b <= 4; b++) expect_beat(1, 32'hC1000000 + 32'(b), b == 4);
`else
    for (int b = 1; b <= 4; b++) begin
      expect_beat(0, 32'hC0000000 + 32'(b), b == 4);
      expect_beat(1, 32'hC1000000 + 32'(b), b == 4);
    end
`endif
    run_until(8, 40);
    compare_out("contend");
    if (cyc_q.size() >= 5) check("contend_pkt_gap", 64'(cyc_q[4] - cyc_q[3]), 64'(2));

    // Fairness: four sources, single-beat packets, eight grants
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM; i++) add(i, 32'hF0000000 + 32'(r * 16 + i), 1'b1);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM; i++) expect_beat(i, 32'hF0000000 + 32'(r * 16 + i), 1'b1);
    end
    run_until(8, 40);
    compare_out("fair");
    for (int k = 0; k < 8; k++) begin
      if (k < grant_q.size()) check($sformatf("fair_grant%0d", k), 64'(grant_q[k]), 64'(k % 4));
    end

    // Backpressure on 0x1234ABCD mid-packet from source 2
    do_reset();
    add(2, 32'h11110001, 1'b0);
    add(2, 32'h1234ABCD, 1'b0);
    add(2, 32'h11110003, 1'b0);
    add(2, 32'h11110004, 1'b1);
    expect_beat(2, 32'h11110001, 1'b0);
    expect_beat(2, 32'h1234ABCD, 1'b0);
    expect_beat(2, 32'h11110003, 1'b0);
    expect_beat(2, 32'h11110004, 1'b1);
    n = 0;
    while (!(m_tvalid && m_tdata == 32'h1234ABCD) && n < 20) begin
      tick();
      n++;
    end
    check("bp_reached", 64'(m_tdata), 64'h1234ABCD);
    m_tready = 1'b0;
    rdy_acc  = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      rdy_acc |= rdy_seen;
    end
    check("bp_hold_beat", dut_beat(), mk(2, 32'h1234ABCD, 1'b0));
    check("bp_hold_valid", 64'(m_tvalid), 64'(1));
    check("bp_tready_low", 64'(rdy_acc), 64'(0));
    m_tready = 1'b1;
    run_until(4, 30);
    compare_out("bp");

    // Asynchronous reset mid-packet
    do_reset();
    for (int b = 1; b <= 4; b++) add(0, 32'hE0000000 + 32'(b), b == 4);
    n = 0;
    while (out_q.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m_tvalid), 64'(0));
    check("midrst_busy", 64'(m_busy), 64'(0));
    check("midrst_data", 64'(m_tdata), 64'(0));
    clear_all();
    tick();
    tick();
    aresetn = 1'b1;
    add(3, 32'hD3000001, 1'b1);
    add(1, 32'hD1000001, 1'b1);
    expect_beat(1, 32'hD1000001, 1'b1);
    expect_beat(3, 32'hD3000001, 1'b1);
    run_until(2, 20);
    compare_out("postrst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
